// File: rtl/conv_2d_ctrl.sv
// Sequencer for the 3x3 convolution core: optional kernel load, then column-per-cycle
// frame streaming band by band, with a 3-stage tag pipeline marking valid output pixels.
module conv_2d_ctrl #(
  parameter int unsigned IMG_W  = 16,
  parameter int unsigned IMG_H  = 16,
  parameter int unsigned NB_COL = 8,
  parameter int unsigned NB_ROW = 8
) (
  input  logic              clk,
  input  logic              i_nrst,
  input  logic              i_start,
  input  logic              i_load_kernel,
  input  logic              i_abort,
  output logic              o_rd_en,
  output logic              o_knl_sel,
  output logic [NB_COL-1:0] o_col_addr,
  output logic [NB_ROW-1:0] o_band_addr,
  output logic              o_load_knl,
  output logic              o_data_valid,
  output logic              o_en_conv,
  output logic              o_px_valid,
  output logic [NB_COL-1:0] o_px_col,
  output logic [NB_ROW-1:0] o_px_row,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {StIdle, StKload, StKwait, StStream, StDrain} state_e;

  localparam logic [NB_COL-1:0] ColLast  = NB_COL'(IMG_W - 1);
  localparam logic [NB_ROW-1:0] BandLast = NB_ROW'(IMG_H - 3);
  localparam logic [NB_COL-1:0] ColTwo   = NB_COL'(2);

  state_e                  state_q, state_d;
  logic [NB_COL-1:0]       col_q, col_d;
  logic [NB_ROW-1:0]       band_q, band_d;
  logic [1:0]              cnt_q, cnt_d;     // kernel column / drain cycle counter
  logic                    done_q, done_d;
  logic [3:0]              ld_sr_q, ld_sr_d; // one-hot walk giving the 4-cycle load window
  logic [2:0]              tag_q, tag_d;     // tag at read+1, read+2, read+3
  logic [2:0][NB_COL-1:0]  pcol_q, pcol_d;
  logic [2:0][NB_ROW-1:0]  prow_q, prow_d;
  logic                    tag0;

  // State and counter next-state logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    band_d  = band_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = i_load_kernel ? StKload : StStream;
          col_d   = '0;
          band_d  = '0;
          cnt_d   = '0;
        end
      end
      StKload: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          state_d = StKwait;
          cnt_d   = '0;
        end
      end
      StKwait: state_d = StStream;
      StStream: begin
        if (col_q == ColLast) begin
          col_d = '0;
          if (band_q == BandLast) begin
            state_d = StDrain;
            band_d  = '0;
            cnt_d   = '0;
          end else begin
            band_d = band_q + NB_ROW'(1);
          end
        end else begin
          col_d = col_q + NB_COL'(1);
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (i_abort) begin
      state_d = StIdle;
      col_d   = '0;
      band_d  = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  // Load-window shifter and pixel tag/coordinate pipeline.
  always_comb begin
    tag0    = (state_q == StStream) && (col_q >= ColTwo);
    ld_sr_d = {ld_sr_q[2:0], (state_q == StKload) && (cnt_q == 2'd0)};
    tag_d   = {tag_q[1:0], tag0};
    pcol_d  = {pcol_q[1:0], tag0 ? (col_q - ColTwo) : NB_COL'(0)};
    prow_d  = {prow_q[1:0], tag0 ? band_q : NB_ROW'(0)};
    if (i_abort) begin
      ld_sr_d = '0;
      tag_d   = '0;
      pcol_d  = '0;
      prow_d  = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= StIdle;
      col_q   <= '0;
      band_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ld_sr_q <= '0;
      tag_q   <= '0;
      pcol_q  <= '0;
      prow_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      band_q  <= band_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ld_sr_q <= ld_sr_d;
      tag_q   <= tag_d;
      pcol_q  <= pcol_d;
      prow_q  <= prow_d;
    end
  end

  // BRAM read port decode from the current state.
  always_comb begin
    o_rd_en     = 1'b0;
    o_knl_sel   = 1'b0;
    o_col_addr  = '0;
    o_band_addr = '0;
    unique case (state_q)
      StKload: begin
        o_rd_en    = 1'b1;
        o_knl_sel  = 1'b1;
        o_col_addr = NB_COL'(cnt_q);
      end
      StStream: begin
        o_rd_en     = 1'b1;
        o_col_addr  = col_q;
        o_band_addr = band_q;
      end
      default: ;
    endcase
  end

  assign o_load_knl   = |ld_sr_q;
  assign o_data_valid = tag_q[1];
  assign o_px_valid   = tag_q[2];
  assign o_px_col     = pcol_q[2];
  assign o_px_row     = prow_q[2];
  assign o_en_conv    = (state_q == StStream) || (state_q == StDrain);
  assign o_busy       = (state_q != StIdle);
  assign o_done       = done_q;

endmodule
